// File: rtl/sipo_deserializer_4bit.sv
// Serial-in, parallel-out deserializer: collects 4 serial bits per word (MSB- or LSB-first)
// and presents each word through a single-entry valid/ready output buffer.
module sipo_deserializer_4bit (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       abort,
  input  logic       msb_first,
  input  logic       serial_in,
  input  logic       bit_valid,
  output logic [3:0] word_out,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic [1:0] bit_cnt,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state, state_n;
  logic [3:0] shift_reg, shift_reg_n;
  logic [1:0] bit_cnt_n;
  logic [3:0] word_out_n;
  logic       word_valid_n;
  logic       overrun_n;
  logic       msb_lat, msb_lat_n;
  logic [3:0] assembled;
  logic       word_done;

  // State and datapath registers; clear returns everything to the idle, empty condition
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= IDLE;
      shift_reg  <= 4'b0000;
      bit_cnt    <= 2'b00;
      word_out   <= 4'b0000;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      msb_lat    <= 1'b1;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_reg_n;
      bit_cnt    <= bit_cnt_n;
      word_out   <= word_out_n;
      word_valid <= word_valid_n;
      overrun    <= overrun_n;
      msb_lat    <= msb_lat_n;
    end
  end

  // Next-state logic: frame control, bit assembly, then the output buffer handshake
  always_comb begin
    state_n      = state;
    shift_reg_n  = shift_reg;
    bit_cnt_n    = bit_cnt;
    word_out_n   = word_out;
    word_valid_n = word_valid;
    overrun_n    = overrun;
    msb_lat_n    = msb_lat;
    word_done    = 1'b0;
    assembled    = msb_lat ? {shift_reg[2:0], serial_in} : {serial_in, shift_reg[3:1]};

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SHIFT;
          shift_reg_n = 4'b0000;
          bit_cnt_n   = 2'b00;
          msb_lat_n   = msb_first;
          overrun_n   = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n     = IDLE;
          shift_reg_n = 4'b0000;
          bit_cnt_n   = 2'b00;
        end else if (bit_valid) begin
          shift_reg_n = assembled;
          bit_cnt_n   = bit_cnt + 2'd1;
          word_done   = (bit_cnt == 2'd3);
        end
      end
      default: state_n = IDLE;
    endcase

    // A completing word either replaces a consumed/empty buffer or is dropped as an overrun
    if (word_done) begin
      if (!word_valid || word_ready) begin
        word_out_n   = assembled;
        word_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (word_valid && word_ready) begin
      word_valid_n = 1'b0;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: doc/sipo_deserializer_4bit.md
SIPO_DESERIALIZER_4BIT -- requirements
Module: sipo_deserializer_4bit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: begins a frame when the block is IDLE.
REQ-004 The block SHALL have port abort, input, 1 bit: ends the frame and discards partial bits.
REQ-005 The block SHALL have port msb_first, input, 1 bit: 1 = first bit received is word bit 3, 0 = first bit is bit 0; captured only at start.
REQ-006 The block SHALL have port serial_in, input, 1 bit: the serial data bit.
REQ-007 The block SHALL have port bit_valid, input, 1 bit: serial_in is sampled on this clock edge.
REQ-008 The block SHALL have port word_out, output, 4 bits: the buffered assembled word.
REQ-009 The block SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-010 The block SHALL have port word_ready, input, 1 bit: the consumer accepts word_out when word_valid=1 and word_ready=1.
REQ-011 The block SHALL have port busy, output, 1 bit: high in the SHIFT state.
REQ-012 The block SHALL have port bit_cnt, output, 2 bits: number of bits in the current partial word (0-3).
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag for a dropped word.

Function
REQ-014 The block SHALL implement two FSM states, IDLE and SHIFT.
REQ-015 IDLE: on start=1, go to SHIFT, set bit_cnt=0, latch msb_first, clear overrun; bit_valid in that same cycle SHALL be ignored.
REQ-016 SHIFT: a start input SHALL be ignored.
REQ-017 SHIFT, each bit_valid=1 with msb_first latched 1: the shift register SHALL left-shift and insert serial_in at bit 0, i.e. {sr[2:0], serial_in}.
REQ-018 SHIFT, each bit_valid=1 with msb_first latched 0: the shift register SHALL right-shift and insert serial_in at bit 3, i.e. {serial_in, sr[3:1]}.
REQ-019 bit_cnt SHALL increment per accepted bit and wrap 3->0 on the 4th bit.
REQ-020 On the edge accepting the 4th bit, the assembled word (including that bit) SHALL load word_out, word_valid=1 visible immediately after that edge (zero extra latency), and the FSM SHALL stay in SHIFT for the next word.
REQ-021 Handshake: word_valid=1 and word_ready=1 at an edge with no word completing SHALL clear word_valid; word_out SHALL retain its value.
REQ-022 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be dropped, word_out and word_valid SHALL be unchanged, and overrun SHALL be set to 1.
REQ-023 If a word completes while word_valid=1 and word_ready=1, the old word SHALL be consumed, the new word SHALL load, word_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-024 abort=1 in SHIFT SHALL go to IDLE, set bit_cnt=0 and discard the partial word; it SHALL win over a simultaneous bit_valid; word_out, word_valid and the handshake SHALL be unaffected.
REQ-025 The output handshake (REQ-021) SHALL operate in both IDLE and SHIFT.
REQ-026 overrun SHALL clear only on clear or on start accepted in IDLE.

Reset
REQ-027 clear=1 SHALL asynchronously force: state IDLE, shift register 0000, bit_cnt 00, word_out 0000, word_valid 0, busy 0, overrun 0, latched msb_first 1.
REQ-028 Reset mid-frame SHALL discard all partial and buffered data; no word SHALL be emitted after clear deasserts until a new start.

Verification
REQ-029 Scenario MSB-first: start with msb_first=1; bits 1,0,1,1; word_ready=1 -> word_out=1011, word_valid=1 for exactly one cycle, bit_cnt=0.
REQ-030 Scenario LSB-first: msb_first=0; bits 1,1,0,1 -> word_out=1011.
REQ-031 Scenario backpressure: word_ready=0; send words 1111 then 0001 (MSB-first) -> word_out=1111, word_valid=1, overrun=1.
REQ-032 Scenario simultaneous: word_out=1111 valid; word_ready=1 on the edge completing 1000 -> word_out=1000, word_valid stays 1, overrun=0.
REQ-033 Scenario abort: abort after bits 1,1; start; bits 0,1,1,0 MSB-first -> word_out=0110, no residue from the aborted bits.
REQ-034 Scenario async reset: clear pulsed between edges mid-frame with word_valid=1 -> all outputs 0 immediately, before the next clk edge.
